id_ex_pipeline_reg: RTL

- Pipeline register between the decode (ID) stage and the execute (EX) stage of the pipelined RISC core.
- Captures the decoder control signals (branch, load, RF-write, shift-imm/S-bit, 4-bit ALU opcode) together with decoded operands and register indices.
- Supports stall (hold), flush (kill), and hazard-bubble insertion (force control to NOP).
- Keeps a saturating count of inserted bubbles for performance debug.

---
 rtl/id_ex_pipeline_reg_if.sv | 54 +++++
 rtl/id_ex_pipeline_reg.sv | 90 +++++++++
 2 files changed

// File: rtl/id_ex_pipeline_reg_if.sv
// ID->EX pipeline-register bundle: decoded ID fields and pipeline controls
// in, registered EX fields and the bubble counter out.
interface id_ex_pipeline_reg_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              flush;
  logic              bubble;

  logic              ID_B_instr;
  logic              ID_load_instr;
  logic              ID_RF_instr;
  logic              ID_shift_imm;
  logic [3:0]        ID_ALU_op;
  logic [3:0]        ID_cond;
  logic [DATA_W-1:0] ID_Rn_val;
  logic [DATA_W-1:0] ID_Rm_val;
  logic [11:0]       ID_shifter_op;
  logic [3:0]        ID_Rd;
  logic              ID_valid;

  logic              EX_B_instr;
  logic              EX_load_instr;
  logic              EX_RF_instr;
  logic              EX_shift_imm;
  logic [3:0]        EX_ALU_op;
  logic [3:0]        EX_cond;
  logic [DATA_W-1:0] EX_Rn_val;
  logic [DATA_W-1:0] EX_Rm_val;
  logic [11:0]       EX_shifter_op;
  logic [3:0]        EX_Rd;
  logic              EX_valid;
  logic [CNT_W-1:0]  bubble_cnt;

  // Hazard/decode side: drives ID fields and pipeline controls.
  modport master (
    output stall, flush, bubble,
    output ID_B_instr, ID_load_instr, ID_RF_instr, ID_shift_imm, ID_ALU_op,
    output ID_cond, ID_Rn_val, ID_Rm_val, ID_shifter_op, ID_Rd, ID_valid,
    input  EX_B_instr, EX_load_instr, EX_RF_instr, EX_shift_imm, EX_ALU_op,
    input  EX_cond, EX_Rn_val, EX_Rm_val, EX_shifter_op, EX_Rd, EX_valid,
    input  bubble_cnt
  );

  modport slave (
    input  stall, flush, bubble,
    input  ID_B_instr, ID_load_instr, ID_RF_instr, ID_shift_imm, ID_ALU_op,
    input  ID_cond, ID_Rn_val, ID_Rm_val, ID_shifter_op, ID_Rd, ID_valid,
    output EX_B_instr, EX_load_instr, EX_RF_instr, EX_shift_imm, EX_ALU_op,
    output EX_cond, EX_Rn_val, EX_Rm_val, EX_shifter_op, EX_Rd, EX_valid,
    output bubble_cnt
  );
endinterface

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with flush > stall > bubble > load priority and a
// saturating count of inserted hazard bubbles.
module id_ex_pipeline_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic                 clk,
  input logic                 reset,
  id_ex_pipeline_reg_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              r_B_instr;
  logic              r_load_instr;
  logic              r_RF_instr;
  logic              r_shift_imm;
  logic [3:0]        r_ALU_op;
  logic [3:0]        r_cond;
  logic [DATA_W-1:0] r_Rn_val;
  logic [DATA_W-1:0] r_Rm_val;
  logic [11:0]       r_shifter_op;
  logic [3:0]        r_Rd;
  logic              r_valid;
  logic [CNT_W-1:0]  r_bubble_cnt;

  // Control is exposed only for a real instruction that is not being bubbled.
  logic w_ctrl_en;
  assign w_ctrl_en = bus.ID_valid & ~bus.bubble;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async reset clears all state, no clock needed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_B_instr    <= 1'b0;
      r_load_instr <= 1'b0;
      r_RF_instr   <= 1'b0;
      r_shift_imm  <= 1'b0;
      r_ALU_op     <= '0;
      r_cond       <= '0;
      r_Rn_val     <= '0;
      r_Rm_val     <= '0;
      r_shifter_op <= '0;
      r_Rd         <= '0;
      r_valid      <= 1'b0;
      r_bubble_cnt <= '0;
    end else if (bus.flush) begin
      r_B_instr    <= 1'b0;
      r_load_instr <= 1'b0;
      r_RF_instr   <= 1'b0;
      r_shift_imm  <= 1'b0;
      r_ALU_op     <= '0;
      r_cond       <= '0;
      r_Rn_val     <= '0;
      r_Rm_val     <= '0;
      r_shifter_op <= '0;
      r_Rd         <= '0;
      r_valid      <= 1'b0;
    end else if (!bus.stall) begin
      r_B_instr    <= bus.ID_B_instr    & w_ctrl_en;
      r_load_instr <= bus.ID_load_instr & w_ctrl_en;
      r_RF_instr   <= bus.ID_RF_instr   & w_ctrl_en;
      r_shift_imm  <= bus.ID_shift_imm  & w_ctrl_en;
      r_ALU_op     <= w_ctrl_en ? bus.ID_ALU_op : 4'b0000;
      r_valid      <= w_ctrl_en;
      r_cond       <= bus.ID_cond;
      r_Rn_val     <= bus.ID_Rn_val;
      r_Rm_val     <= bus.ID_Rm_val;
      r_shifter_op <= bus.ID_shifter_op;
      r_Rd         <= bus.ID_Rd;
      if (bus.bubble && (r_bubble_cnt != CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end
  end

  assign bus.EX_B_instr    = r_B_instr;
  assign bus.EX_load_instr = r_load_instr;
  assign bus.EX_RF_instr   = r_RF_instr;
  assign bus.EX_shift_imm  = r_shift_imm;
  assign bus.EX_ALU_op     = r_ALU_op;
  assign bus.EX_cond       = r_cond;
  assign bus.EX_Rn_val     = r_Rn_val;
  assign bus.EX_Rm_val     = r_Rm_val;
  assign bus.EX_shifter_op = r_shifter_op;
  assign bus.EX_Rd         = r_Rd;
  assign bus.EX_valid      = r_valid;
  assign bus.bubble_cnt    = r_bubble_cnt;

endmodule
